// File: rtl/register_file_reader.sv
// rtl/register_file_reader.sv - integer register file with two bypassed read ports and a serial dump engine
module register_file_reader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata2,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [WIDTH-1:0]  dump_data,
  output logic              dump_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [ADDR_W-1:0] next_idx;
  logic [WIDTH-1:0]  next_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we && waddr != '0) begin
      regs_q[waddr] <= wdata;
    end
  end

  // x0 reads as zero; otherwise a same-cycle write wins over the stored value
  always_comb begin
    rdata1 = regs_q[raddr1];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (raddr1 == '0) rdata1 = '0;
  end

  always_comb begin
    rdata2 = regs_q[raddr2];
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr2 == '0) rdata2 = '0;
  end

  assign next_idx = addr_q + ADDR_W'(1);

  always_comb begin
    next_word = regs_q[next_idx];
    if (we && waddr == next_idx) next_word = wdata;
    if (next_idx == '0) next_word = '0;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          addr_d  = '0;
          data_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (dump_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d = next_idx;
            data_d = next_word;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign dump_valid = (state_q == SEND);
  assign dump_done  = (state_q == DONE);
  assign dump_busy  = dump_valid | dump_done;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;

endmodule

// File: tb/tb_register_file_reader.sv
// tb/tb_register_file_reader.sv - scoreboard bench for register_file_reader
module tb_register_file_reader;

  logic        clock = 0;
  logic        reset = 1;
  logic        we = 0;
  logic [4:0]  waddr = 0;
  logic [31:0] wdata = 0;
  logic [4:0]  raddr1 = 0;
  logic [31:0] rdata1;
  logic [4:0]  raddr2 = 0;
  logic [31:0] rdata2;
  logic        dump_start = 0;
  logic        dump_busy;
  logic        dump_valid;
  logic        dump_ready = 0;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_done;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];
  logic [4:0]  exp_addr [$];
  logic [31:0] exp_data [$];
  logic        prev_stall = 0;
  logic [4:0]  prev_addr = 0;
  logic [31:0] prev_data = 0;

  register_file_reader dut (
    .clock(clock), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  always #5 clock = ~clock;

  // Scoreboard: every accepted word must match the next snapshot entry; stalled words must hold
  always @(negedge clock) begin
    if (reset) begin
      prev_stall <= 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (dump_valid !== 1'b1 || dump_addr !== prev_addr || dump_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b addr=%0d data=%h expected v=1 addr=%0d data=%h",
                   dump_valid, dump_addr, dump_data, prev_addr, prev_data);
        end
      end
      prev_stall <= dump_valid && !dump_ready;
      prev_addr  <= dump_addr;
      prev_data  <= dump_data;
      if (dump_valid && dump_ready) begin
        checks++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got addr=%0d data=%h expected none", dump_addr, dump_data);
        end else begin
          automatic logic [4:0]  ea = exp_addr.pop_front();
          automatic logic [31:0] ed = exp_data.pop_front();
          if (dump_addr !== ea || dump_data !== ed) begin
            errors++;
            $display("FAIL dump_word: got addr=%0d data=%h expected addr=%0d data=%h",
                     dump_addr, dump_data, ea, ed);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
    step();
    we = 0;
    if (a != 0) model[a] = d;
  endtask

  task automatic push_dump();
    for (int i = 0; i < 32; i++) begin
      exp_addr.push_back(5'(i));
      exp_data.push_back(model[i]);
    end
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_addr.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d words pending expected 0", name, exp_addr.size());
      exp_addr.delete();
      exp_data.delete();
    end
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        errors++;
        $display("FAIL %s: addr %0d got r1=%h r2=%h expected 0", name, i, rdata1, rdata2);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (dump_valid !== 0 || dump_busy !== 0 || dump_done !== 0 || dump_addr !== 0 || dump_data !== 0) begin
      errors++;
      $display("FAIL reset_dump: got v=%0b b=%0b d=%0b addr=%0d data=%h expected all 0",
               dump_valid, dump_busy, dump_done, dump_addr, dump_data);
    end
    read_all_zero("reset_read");
  endtask

  task automatic test_write_read();
    wr(5'd5, 32'hDEADBEEF);
    raddr1 = 5'd5; raddr2 = 5'd0;
    #1;
    checks++;
    if (rdata1 !== model[5] || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL write_read: got r1=%h r2=%h expected r1=%h r2=0", rdata1, rdata2, model[5]);
    end
    we = 1; waddr = 5'd0; wdata = 32'h1234; raddr1 = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL x0_bypass: got %h expected 0", rdata1);
    end
    step();
    we = 0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL x0_write: got %h expected 0", rdata1);
    end
  endtask

  task automatic test_bypass();
    we = 1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr2 = 5'd7; raddr1 = 5'd5;
    #1;
    checks++;
    if (rdata2 !== 32'hA5A5A5A5 || rdata1 !== model[5]) begin
      errors++;
      $display("FAIL bypass: got r2=%h r1=%h expected r2=a5a5a5a5 r1=%h", rdata2, rdata1, model[5]);
    end
    step();
    we = 0;
    model[7] = 32'hA5A5A5A5;
    #1;
    checks++;
    if (rdata2 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_stored: got %h expected a5a5a5a5", rdata2);
    end
  endtask

  task automatic test_dump_full();
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 3));
    dump_ready = 1;
    dump_start = 1;
    push_dump();
    step();
    // k counts cycles after the start-sampling edge; a stray start at k=5 must be ignored
    for (int k = 1; k <= 34; k++) begin
      dump_start = (k == 5 || k == 34);
      @(negedge clock);
      checks++;
      if (dump_valid !== (k <= 32) || dump_done !== (k == 33) || dump_busy !== (k <= 33)) begin
        errors++;
        $display("FAIL dump_timing: cycle %0d got v=%0b d=%0b b=%0b expected v=%0b d=%0b b=%0b",
                 k, dump_valid, dump_done, dump_busy, k <= 32, k == 33, k <= 33);
      end
      if (k == 34) push_dump();
      step();
    end
    dump_start = 0;
    checks++;
    if (dump_valid !== 1'b1 || dump_addr !== 5'd0) begin
      errors++;
      $display("FAIL restart: got v=%0b addr=%0d expected v=1 addr=0", dump_valid, dump_addr);
    end
    while (dump_valid) step();
    step();
    check_queue_empty("dump_full_count");
  endtask

  task automatic test_dump_random_ready();
    bit wrote = 0;
    bit seen_done = 0;
    dump_start = 1;
    push_dump();
    step();
    dump_start = 0;
    for (int c = 0; c < 600 && !seen_done; c++) begin
      dump_ready = 1'($urandom_range(0, 1));
      if (!wrote && dump_valid && dump_addr >= 5'd11) begin
        we = 1; waddr = 5'd10; wdata = 32'h55;
        wrote = 1;
        model[10] = 32'h55;
      end else begin
        we = 0;
      end
      @(negedge clock);
      if (dump_done) seen_done = 1;
      step();
    end
    we = 0;
    dump_ready = 0;
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL random_done: got no done pulse expected one within 600 cycles");
    end
    check_queue_empty("random_count");
    raddr1 = 5'd10;
    #1;
    checks++;
    if (rdata1 !== 32'h55) begin
      errors++;
      $display("FAIL x10_after: got %h expected 00000055", rdata1);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit hit = 0;
    dump_ready = 1;
    dump_start = 1;
    push_dump();
    step();
    dump_start = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clock);
      if (dump_valid && dump_addr == 5'd12) hit = 1;
      else step();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reach_addr12: got addr=%0d expected 12 within 100 cycles", dump_addr);
    end
    #2;
    reset = 1;
    #1;
    checks++;
    if (dump_valid !== 0 || dump_busy !== 0 || dump_done !== 0 || dump_addr !== 0 || dump_data !== 0) begin
      errors++;
      $display("FAIL mid_reset: got v=%0b b=%0b d=%0b addr=%0d data=%h expected all 0",
               dump_valid, dump_busy, dump_done, dump_addr, dump_data);
    end
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < 32; i++) model[i] = 0;
    @(negedge clock);
    reset = 0;
    step();
    checks++;
    if (dump_done !== 0 || dump_busy !== 0) begin
      errors++;
      $display("FAIL no_done_after_reset: got d=%0b b=%0b expected 0", dump_done, dump_busy);
    end
    read_all_zero("mid_reset_read");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 0;
    repeat (2) @(negedge clock);
    reset = 0;
    step();
    test_reset();
    test_write_read();
    test_bypass();
    test_dump_full();
    test_dump_random_ready();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
